// File: rtl/lab4_ctrl_if.sv
`default_nettype none
// ============================================================================
//  lab4_ctrl_if : requester, operand, result and status bundle for lab4_ctrl
//  Revision 1.0
// ============================================================================
interface lab4_ctrl_if;
  logic       req0;
  logic       req1;
  logic [9:0] x1_0;
  logic [9:0] x2_0;
  logic [9:0] x3_0;
  logic [9:0] x1_1;
  logic [9:0] x2_1;
  logic [9:0] x3_1;
  logic       ack0;
  logic       ack1;
  logic [9:0] y_out;
  logic       y_id;
  logic       y_valid;
  logic       y_ready;
  logic       busy;

  modport master (
    output req0, req1, x1_0, x2_0, x3_0, x1_1, x2_1, x3_1, y_ready,
    input  ack0, ack1, y_out, y_id, y_valid, busy
  );

  modport slave (
    input  req0, req1, x1_0, x2_0, x3_0, x1_1, x2_1, x3_1, y_ready,
    output ack0, ack1, y_out, y_id, y_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/lab4_ctrl.sv
`default_nettype none
// ============================================================================
//  lab4_ctrl : two-requester round-robin front end for one lab4dpath
//  Revision 1.0
// ============================================================================

module lab4dpath (
  input  logic [9:0] x1,
  input  logic [9:0] x2,
  input  logic [9:0] x3,
  output logic [9:0] y
);
  // multiply-add, result wraps to 10 bits
  assign y = x1 * x2 + x3;
endmodule

module lab4_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  lab4_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] x1_q, x1_d;
  logic [9:0] x2_q, x2_d;
  logic [9:0] x3_q, x3_d;
  logic       id_q, id_d;
  logic [9:0] y_out_q, y_out_d;
  logic       y_id_q, y_id_d;
  logic       y_valid_q, y_valid_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [9:0] dp_y;
  logic       grant0;
  logic       grant1;

  lab4dpath u_dpath (
    .x1 (x1_q),
    .x2 (x2_q),
    .x3 (x3_q),
    .y  (dp_y)
  );

  // rr_q == 0 favours requester 0 when both are asking
  assign grant0 = bus.req0 && (!bus.req1 || !rr_q);
  assign grant1 = bus.req1 && (!bus.req0 ||  rr_q);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    id_d      = id_q;
    y_out_d   = y_out_q;
    y_id_d    = y_id_q;
    y_valid_d = y_valid_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant0) begin
          x1_d    = bus.x1_0;
          x2_d    = bus.x2_0;
          x3_d    = bus.x3_0;
          id_d    = 1'b0;
          rr_d    = 1'b1;
          ack0_d  = 1'b1;
          cnt_d   = 4'(SETTLE_CYCLES);
          state_d = WAIT;
        end else if (grant1) begin
          x1_d    = bus.x1_1;
          x2_d    = bus.x2_1;
          x3_d    = bus.x3_1;
          id_d    = 1'b1;
          rr_d    = 1'b0;
          ack1_d  = 1'b1;
          cnt_d   = 4'(SETTLE_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          y_out_d   = dp_y;
          y_id_d    = id_q;
          y_valid_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // leaving DONE spends one cycle in IDLE before any new grant
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= 4'd0;
      x1_q      <= 10'd0;
      x2_q      <= 10'd0;
      x3_q      <= 10'd0;
      id_q      <= 1'b0;
      y_out_q   <= 10'd0;
      y_id_q    <= 1'b0;
      y_valid_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      x3_q      <= x3_d;
      id_q      <= id_d;
      y_out_q   <= y_out_d;
      y_id_q    <= y_id_d;
      y_valid_q <= y_valid_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.y_out   = y_out_q;
  assign bus.y_id    = y_id_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_lab4_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_lab4_ctrl : directed self-checking bench for lab4_ctrl (SETTLE_CYCLES=2)
//  Revision 1.0
// ============================================================================
module tb_lab4_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  lab4_ctrl_if bus ();

  lab4_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // hand-computed (x1*x2 + x3) mod 1024
  localparam logic [9:0] Y_V0 = 10'h016;  // 3*5+7      = 22
  localparam logic [9:0] Y_V1 = 10'h0E6;  // 10*20+30   = 230
  localparam logic [9:0] Y_V2 = 10'h0B1;  // 100*12+1   = 1201 -> 177
  localparam logic [9:0] Y_V3 = 10'h210;  // 512*3+16   = 1552 -> 528
  localparam logic [9:0] Y_V4 = 10'h000;  // 1023*1023+1023 = 0xFFC00 -> 0

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk10(tag, {9'd0, obs}, {9'd0, exp});
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    chk10(tag, {8'd0, obs}, {8'd0, exp});
  endtask

  task automatic set_op0(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    bus.x1_0 = a; bus.x2_0 = b; bus.x3_0 = c;
  endtask

  task automatic set_op1(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    bus.x1_1 = a; bus.x2_1 = b; bus.x3_1 = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input logic id, input string tag);
    int n = 0;
    while (!(bus.ack0 || bus.ack1) && n < 20) begin
      step();
      n++;
    end
    chk2(tag, {bus.ack1, bus.ack0}, id ? 2'b10 : 2'b01);
  endtask

  task automatic wait_valid(input logic id, input logic [9:0] y, input string tag);
    int n = 0;
    while (!bus.y_valid && n < 20) begin
      step();
      n++;
    end
    chk1({tag, "_valid"}, bus.y_valid, 1'b1);
    chk10({tag, "_y"}, bus.y_out, y);
    chk1({tag, "_id"}, bus.y_id, id);
  endtask

  initial begin
    reset       = 1'b1;
    bus.req0    = 1'b1;
    bus.req1    = 1'b1;
    bus.y_ready = 1'b1;
    set_op0(10'd3, 10'd5, 10'd7);
    set_op1(10'd9, 10'd9, 10'd9);

    // reset held with both requests high
    for (int i = 0; i < 2; i++) begin
      step();
      chk2($sformatf("rst%0d_ack", i), {bus.ack1, bus.ack0}, 2'b00);
      chk1($sformatf("rst%0d_valid", i), bus.y_valid, 1'b0);
      chk1($sformatf("rst%0d_busy", i), bus.busy, 1'b0);
      chk10($sformatf("rst%0d_y", i), bus.y_out, 10'h000);
    end

    // single request from requester 0, exact latency
    reset    = 1'b0;
    bus.req1 = 1'b0;
    step();
    chk2("lat_ack", {bus.ack1, bus.ack0}, 2'b01);
    chk1("lat_busy", bus.busy, 1'b1);
    bus.req0 = 1'b0;
    set_op0(10'h155, 10'h155, 10'h155);
    step();
    chk2("lat_ack_drop", {bus.ack1, bus.ack0}, 2'b00);
    chk1("lat_early_valid", bus.y_valid, 1'b0);
    step();
    chk1("lat_valid", bus.y_valid, 1'b1);
    chk10("lat_y", bus.y_out, Y_V0);
    chk1("lat_id", bus.y_id, 1'b0);
    step();
    chk1("lat_valid_clr", bus.y_valid, 1'b0);
    chk1("lat_idle", bus.busy, 1'b0);

    // round robin with both held
    set_op0(10'd10, 10'd20, 10'd30);
    set_op1(10'd100, 10'd12, 10'd1);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'(i % 2), $sformatf("rr%0d_ack", i));
      wait_valid(1'(i % 2), (i % 2) ? Y_V2 : Y_V1, $sformatf("rr%0d", i));
    end

    // back-pressure in DONE with requester 1 pending
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    do_reset();
    bus.y_ready = 1'b0;
    bus.req0    = 1'b1;
    wait_ack(1'b0, "bp_ack0");
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    set_op1(10'h200, 10'd3, 10'h010);
    wait_valid(1'b0, Y_V1, "bp_first");
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("bp%0d_valid", i), bus.y_valid, 1'b1);
      chk10($sformatf("bp%0d_y", i), bus.y_out, Y_V1);
      chk1($sformatf("bp%0d_id", i), bus.y_id, 1'b0);
      chk1($sformatf("bp%0d_ack1", i), bus.ack1, 1'b0);
    end
    bus.y_ready = 1'b1;
    step();
    chk1("bp_leave_valid", bus.y_valid, 1'b0);
    chk1("bp_leave_busy", bus.busy, 1'b0);
    chk1("bp_leave_ack1", bus.ack1, 1'b0);
    step();
    chk2("bp_grant1", {bus.ack1, bus.ack0}, 2'b10);
    bus.req1 = 1'b0;
    wait_valid(1'b1, Y_V3, "bp_second");

    // reset during WAIT discards the transaction and clears rr
    set_op0(10'd100, 10'd12, 10'd1);
    set_op1(10'd10, 10'd20, 10'd30);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    do_reset();
    wait_ack(1'b0, "rw_ack_a");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("rw_valid", bus.y_valid, 1'b0);
    chk1("rw_busy", bus.busy, 1'b0);
    chk2("rw_ack", {bus.ack1, bus.ack0}, 2'b00);
    step();
    chk2("rw_regrant0", {bus.ack1, bus.ack0}, 2'b01);
    chk1("rw_no_valid", bus.y_valid, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_valid(1'b0, Y_V2, "rw_result");
    step();

    // all-ones operands from requester 1 wrap to zero
    set_op1(10'h3FF, 10'h3FF, 10'h3FF);
    bus.req1 = 1'b1;
    wait_ack(1'b1, "max_ack");
    bus.req1 = 1'b0;
    wait_valid(1'b1, Y_V4, "max");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lab4_ctrl.md
LAB4_CTRL -- requirements
Module: lab4_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the number of cycles operands are held on the datapath before y is captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1; held high with stable operands until the matching ack.
REQ-005 x1_0, x2_0, x3_0  input  10 each  operands from requester 0.
REQ-006 x1_1, x2_1, x3_1  input  10 each  operands from requester 1.
REQ-007 ack0, ack1  output  1 each  one-cycle grant/capture acknowledge to requester 0 / 1.
REQ-008 y_out  output  10  captured lab4dpath result.
REQ-009 y_id  output  1  requester index owning y_out.
REQ-010 y_valid  output  1  y_out/y_id valid.
REQ-011 y_ready  input  1  consumer accepts the result when y_valid is high.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL instantiate one lab4dpath; its x1/x2/x3 inputs SHALL be driven only from internal 10-bit operand registers.
REQ-014 FSM states SHALL be IDLE, WAIT and DONE.
REQ-015 IDLE: with no req high, the block SHALL stay in IDLE with operand registers unchanged.
REQ-016 IDLE, exactly one req high: at that edge, the block SHALL grant that requester, latch its operands, load the counter with SETTLE_CYCLES, record its id and go to WAIT.
REQ-017 IDLE, both req high: the block SHALL grant the requester selected by the round-robin pointer rr.
REQ-018 After each grant to requester N, rr SHALL be set to the other requester; rr SHALL not change otherwise.
REQ-019 ackN SHALL be high for exactly the one cycle following the grant edge; the other ack SHALL stay low.
REQ-020 Operands latched SHALL be those present at the grant edge; later input changes SHALL have no effect on the transaction.
REQ-021 WAIT: each edge SHALL decrement the counter; at the edge where the counter equals 1, y_out SHALL capture lab4dpath y, y_id SHALL take the recorded id, and the FSM SHALL go to DONE with y_valid high.
REQ-022 Latency: y_valid SHALL first be high in the cycle after edge G+SETTLE_CYCLES, where G is the grant edge.
REQ-023 DONE: y_valid, y_out and y_id SHALL hold stable until an edge with y_ready high, which SHALL return the FSM to IDLE and clear y_valid.
REQ-024 No grant SHALL occur in the cycle that leaves DONE; requests pending through WAIT/DONE SHALL be arbitrated on the first IDLE edge.
REQ-025 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-026 A req dropped before being granted SHALL be ignored, with no ack.
REQ-027 y_out SHALL be the 10-bit datapath output unmodified; no widening or saturation.

Reset
REQ-028 On a reset edge, the block SHALL force state IDLE, rr=0, counter=0, operand registers=0, y_out=0, y_id=0, y_valid=0, ack0=ack1=0, busy=0, regardless of state or inputs.
REQ-029 Reset mid-WAIT or mid-DONE SHALL discard the transaction with no y_valid pulse; reset SHALL take priority over request, ack and y_ready in the same cycle.

Verification
REQ-030 Hold reset 2 cycles with req0=req1=1 -> ack0=ack1=0, y_valid=0, busy=0, y_out=0x000 throughout.
REQ-031 SETTLE_CYCLES=2, y_ready=1, req0 with first multadd_vectors.txt entry -> ack0 high 1 cycle after grant; y_valid high 2 cycles after grant for 1 cycle; y_id=0; y_out equals the vector result.
REQ-032 After reset, req0 and req1 high simultaneously and held -> grants alternate 0,1,0,1; y_id sequence 0,1,0,1; every y_out matches its vector.
REQ-033 y_ready=0 for 5 cycles in DONE while req1 pending -> y_valid, y_out and y_id stable, ack1=0; after y_ready=1, FSM spends one cycle in IDLE and then grants requester 1.
REQ-034 Assert reset during WAIT -> no y_valid for that transaction; next simultaneous request is granted to requester 0.
REQ-035 Operands 0x3FF, 0x3FF, 0x3FF from requester 1 -> y_out equals the vector-file result for those operands (10-bit); y_id=1.
